// File: rtl/rp_8bit_itrace.sv
// Instruction trace capture: assembles fetched program words into 1- or 2-word AVR
// instructions and queues {pc, opcode, length} records on a valid/ready stream.
module rp_8bit_itrace #(
  parameter int unsigned PAW        = 11,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_vld,
  input  logic [PAW-1:0]   bus_adr,
  input  logic [15:0]      bus_dat,
  input  logic             bus_flush,
  output logic             trc_vld,
  input  logic             trc_rdy,
  output logic [PAW-1:0]   trc_pc,
  output logic [31:0]      trc_op,
  output logic             trc_len,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] seq_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned RW = PAW + 33;
  localparam logic [AW:0] DepthCnt = (AW+1)'(FIFO_DEPTH);

  localparam logic [0:0] StFirst  = 1'b0;
  localparam logic [0:0] StSecond = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [PAW-1:0] hold_pc_q, hold_pc_d;
  logic [15:0]    hold_op_q, hold_op_d;
  logic [PAW-1:0] hold_pc_inc;
  logic           is_two, held, push, seq_inc;
  logic [RW-1:0]  rec;

  assign hold_pc_inc = hold_pc_q + PAW'(1);
  // lds/sts and jmp/call carry a second opcode word
  assign is_two = (bus_dat[15:10] == 6'b100100 && bus_dat[3:0] == 4'b0000) ||
                  (bus_dat[15:9] == 7'b1001010 && bus_dat[3:2] == 2'b11);

  always_comb begin
    state_d   = state_q;
    hold_pc_d = hold_pc_q;
    hold_op_d = hold_op_q;
    push      = 1'b0;
    seq_inc   = 1'b0;
    rec       = '0;
    // A flush discards the held word before any same-cycle fetch is considered
    held      = (state_q == StSecond) && !bus_flush;
    if (bus_flush) state_d = StFirst;
    if (bus_vld) begin
      if (held && bus_adr == hold_pc_inc) begin
        push    = 1'b1;
        rec     = {hold_pc_q, bus_dat, hold_op_q, 1'b1};
        state_d = StFirst;
      end else begin
        seq_inc = held;
        if (is_two) begin
          state_d   = StSecond;
          hold_pc_d = bus_adr;
          hold_op_d = bus_dat;
        end else begin
          push    = 1'b1;
          rec     = {bus_adr, 16'h0000, bus_dat, 1'b0};
          state_d = StFirst;
        end
      end
    end
  end

  logic [RW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [RW-1:0] out_q, out_d;
  logic          full, pop, fifo_wr, ovf_inc;

  assign full    = (cnt_q == DepthCnt);
  assign pop     = trc_vld && trc_rdy;
  assign fifo_wr = push && (!full || pop);
  assign ovf_inc = push && full && !pop;

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = fifo_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cnt_d    = cnt_q;
    if (fifo_wr && !pop) cnt_d = cnt_q + (AW+1)'(1);
    else if (!fifo_wr && pop) cnt_d = cnt_q - (AW+1)'(1);
    out_d = out_q;
    // Registered head; the incoming record bypasses memory when it becomes the head
    if (cnt_d != '0) begin
      out_d = (fifo_wr && rd_ptr_d == wr_ptr_q) ? rec : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFirst;
      hold_pc_q <= '0;
      hold_op_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      ovf_cnt   <= '0;
      seq_err   <= '0;
    end else begin
      state_q   <= state_d;
      hold_pc_q <= hold_pc_d;
      hold_op_q <= hold_op_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      if (ovf_inc && ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_W'(1);
      if (seq_inc && seq_err != '1) seq_err <= seq_err + CNT_W'(1);
    end
  end

  assign trc_vld = (cnt_q != '0);
  assign trc_pc  = out_q[RW-1 -: PAW];
  assign trc_op  = out_q[32:1];
  assign trc_len = out_q[0];

endmodule

// File: tb/tb_rp_8bit_itrace.sv
// Bench for rp_8bit_itrace: directed vector table, multi-cycle corner sequences and
// random traffic against a queue-based reference model.
module tb_rp_8bit_itrace;

  localparam int PAW   = 11;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst, bus_vld, bus_flush, trc_rdy;
  logic [PAW-1:0]  bus_adr;
  logic [15:0]     bus_dat;
  logic            trc_vld, trc_len;
  logic [PAW-1:0]  trc_pc;
  logic [31:0]     trc_op;
  logic [15:0]     ovf_cnt, seq_err;

  int n_tests = 0;
  int n_fail  = 0;

  rp_8bit_itrace #(.PAW(PAW), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_vld   (bus_vld),
    .bus_adr   (bus_adr),
    .bus_dat   (bus_dat),
    .bus_flush (bus_flush),
    .trc_vld   (trc_vld),
    .trc_rdy   (trc_rdy),
    .trc_pc    (trc_pc),
    .trc_op    (trc_op),
    .trc_len   (trc_len),
    .ovf_cnt   (ovf_cnt),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic bv, input logic [PAW-1:0] a, input logic [15:0] d,
                       input logic fl, input logic rdy);
    bus_vld = bv; bus_adr = a; bus_dat = d; bus_flush = fl; trc_rdy = rdy;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_vld = 1'b0; bus_adr = '0; bus_dat = '0; bus_flush = 1'b0; trc_rdy = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [PAW-1:0] pc;
    logic [31:0]    op;
    logic           len;
  } rec_t;

  rec_t           mq[$];
  bit             pend;
  logic [PAW-1:0] pend_pc;
  logic [15:0]    pend_op;
  int             m_ovf, m_seq;
  rec_t           m_out;

  function automatic bit two_word(input logic [15:0] d);
    return (d ==? 16'b1001_00??_????_0000) || (d ==? 16'b1001_010?_????_11??);
  endfunction

  task automatic model_reset();
    mq.delete();
    pend = 0; pend_pc = '0; pend_op = '0;
    m_ovf = 0; m_seq = 0;
    m_out = '{pc: '0, op: '0, len: 1'b0};
  endtask

  task automatic model_cycle(input logic bv, input logic [PAW-1:0] a, input logic [15:0] d,
                             input logic fl, input logic rdy);
    bit             have, pop, full;
    rec_t           r;
    logic [PAW-1:0] nxt;
    have = 0;
    r = '{pc: '0, op: '0, len: 1'b0};
    if (fl) pend = 0;
    nxt = pend_pc + 1;
    if (bv) begin
      if (pend && a == nxt) begin
        r = '{pc: pend_pc, op: {d, pend_op}, len: 1'b1};
        have = 1; pend = 0;
      end else begin
        if (pend && m_seq < 65535) m_seq++;
        pend = 0;
        if (two_word(d)) begin
          pend = 1; pend_pc = a; pend_op = d;
        end else begin
          r = '{pc: a, op: {16'h0000, d}, len: 1'b0};
          have = 1;
        end
      end
    end
    pop  = (mq.size() > 0) && rdy;
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (have) begin
      if (full && !pop) begin
        if (m_ovf < 65535) m_ovf++;
      end else mq.push_back(r);
    end
    if (mq.size() > 0) m_out = mq[0];
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic           bv;
    logic [PAW-1:0] adr;
    logic [15:0]    dat;
    logic           fl;
    logic           rdy;
    logic           e_vld;
    logic [PAW-1:0] e_pc;
    logic [31:0]    e_op;
    logic           e_len;
    logic [15:0]    e_seq;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [PAW-1:0] adr_r;
    logic [15:0]    dat_r;
    logic           bv_r, fl_r, rdy_r;

    tbl[0]  = '{1, 11'h010, 16'h0C01, 0, 1, 1, 11'h010, 32'h0000_0C01, 0, 16'd0};
    tbl[1]  = '{0, 11'h000, 16'h0000, 0, 1, 0, 11'h010, 32'h0000_0C01, 0, 16'd0};
    tbl[2]  = '{1, 11'h020, 16'h9100, 0, 1, 0, 11'h010, 32'h0000_0C01, 0, 16'd0};
    tbl[3]  = '{1, 11'h021, 16'h0100, 0, 1, 1, 11'h020, 32'h0100_9100, 1, 16'd0};
    tbl[4]  = '{0, 11'h000, 16'h0000, 0, 1, 0, 11'h020, 32'h0100_9100, 1, 16'd0};
    tbl[5]  = '{1, 11'h030, 16'h940C, 0, 1, 0, 11'h020, 32'h0100_9100, 1, 16'd0};
    tbl[6]  = '{1, 11'h040, 16'h0000, 1, 1, 1, 11'h040, 32'h0000_0000, 0, 16'd0};
    tbl[7]  = '{0, 11'h000, 16'h0000, 0, 1, 0, 11'h040, 32'h0000_0000, 0, 16'd0};
    tbl[8]  = '{1, 11'h050, 16'h940E, 0, 1, 0, 11'h040, 32'h0000_0000, 0, 16'd0};
    tbl[9]  = '{1, 11'h060, 16'h2700, 0, 1, 1, 11'h060, 32'h0000_2700, 0, 16'd1};
    tbl[10] = '{0, 11'h000, 16'h0000, 0, 1, 0, 11'h060, 32'h0000_2700, 0, 16'd1};

    do_reset();
    check("rst_vld", 64'(trc_vld), 64'd0);
    check("rst_pc",  64'(trc_pc),  64'd0);
    check("rst_op",  64'(trc_op),  64'd0);
    check("rst_len", 64'(trc_len), 64'd0);
    check("rst_ovf", 64'(ovf_cnt), 64'd0);
    check("rst_seq", 64'(seq_err), 64'd0);

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].bv, tbl[i].adr, tbl[i].dat, tbl[i].fl, tbl[i].rdy);
      check($sformatf("vec%0d_vld", i), 64'(trc_vld), 64'(tbl[i].e_vld));
      check($sformatf("vec%0d_pc", i),  64'(trc_pc),  64'(tbl[i].e_pc));
      check($sformatf("vec%0d_op", i),  64'(trc_op),  64'(tbl[i].e_op));
      check($sformatf("vec%0d_len", i), 64'(trc_len), 64'(tbl[i].e_len));
      check($sformatf("vec%0d_seq", i), 64'(seq_err), 64'(tbl[i].e_seq));
    end

    // Overflow: six fetches into a 4-deep FIFO with the consumer stalled
    for (int i = 0; i < 6; i++) apply(1, 11'h100 + 11'(i), 16'h0000, 0, 0);
    check("ovf_vld", 64'(trc_vld), 64'd1);
    check("ovf_pc",  64'(trc_pc),  64'h100);
    check("ovf_cnt", 64'(ovf_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_vld", i), 64'(trc_vld), 64'd1);
      check($sformatf("drain%0d_pc", i),  64'(trc_pc),  64'(11'h100 + 11'(i)));
      apply(0, '0, '0, 0, 1);
    end
    check("drain_empty", 64'(trc_vld), 64'd0);

    // Full FIFO with simultaneous pop and push: no drop
    for (int i = 0; i < 4; i++) apply(1, 11'h200 + 11'(i), 16'h1111, 0, 0);
    check("full_ovf", 64'(ovf_cnt), 64'd2);
    apply(1, 11'h204, 16'h2222, 0, 1);
    check("fullpp_ovf", 64'(ovf_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fpp%0d_vld", i), 64'(trc_vld), 64'd1);
      check($sformatf("fpp%0d_pc", i),  64'(trc_pc),  64'(11'h201 + 11'(i)));
      apply(0, '0, '0, 0, 1);
    end
    check("fpp_empty", 64'(trc_vld), 64'd0);

    // Reset while holding a first word discards it
    apply(1, 11'h070, 16'h9200, 0, 1);
    check("hold_novld", 64'(trc_vld), 64'd0);
    rst = 1'b1;
    apply(0, '0, '0, 0, 1);
    rst = 1'b0;
    apply(1, 11'h071, 16'h0000, 0, 1);
    check("rsthold_vld", 64'(trc_vld), 64'd1);
    check("rsthold_pc",  64'(trc_pc),  64'h071);
    check("rsthold_len", 64'(trc_len), 64'd0);
    check("rsthold_op",  64'(trc_op),  64'd0);
    check("rsthold_ovf", 64'(ovf_cnt), 64'd0);
    check("rsthold_seq", 64'(seq_err), 64'd0);

    // Random traffic against the reference model
    do_reset();
    model_reset();
    adr_r = 11'h3F0;
    for (int i = 0; i < 3000; i++) begin
      bv_r  = ($urandom_range(0, 9) < 6);
      fl_r  = ($urandom_range(0, 9) == 0);
      rdy_r = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 8) adr_r = adr_r + 11'd1;
      else adr_r = 11'($urandom);
      case ($urandom_range(0, 3))
        0:       dat_r = 16'h940C | (16'($urandom) & 16'h01F3);
        1:       dat_r = 16'h9000 | (16'($urandom) & 16'h03F0);
        default: dat_r = 16'($urandom);
      endcase
      model_cycle(bv_r, adr_r, dat_r, fl_r, rdy_r);
      apply(bv_r, adr_r, dat_r, fl_r, rdy_r);
      check($sformatf("rnd%0d_vld", i), 64'(trc_vld), 64'(mq.size() > 0));
      check($sformatf("rnd%0d_pc", i),  64'(trc_pc),  64'(m_out.pc));
      check($sformatf("rnd%0d_op", i),  64'(trc_op),  64'(m_out.op));
      check($sformatf("rnd%0d_len", i), 64'(trc_len), 64'(m_out.len));
      check($sformatf("rnd%0d_ovf", i), 64'(ovf_cnt), 64'(m_ovf));
      check($sformatf("rnd%0d_seq", i), 64'(seq_err), 64'(m_seq));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rp_8bit_itrace.md
Name: rp_8bit_itrace

Overview:
- Instruction trace capture stage. Watches the program-memory fetch bus of the rp_8bit core and assembles fetched words into complete AVR instructions, one or two words each.
- Buffers each assembled instruction with its PC in a small FIFO. The FIFO presents records on a valid/ready stream.
- Sits directly upstream of the disassembler in the bench and trace path. Each record carries exactly the opcode word(s) the disassembler consumes.

Parameters:
- PAW, 11, program word-address width.
- FIFO_DEPTH, 4, record FIFO depth; power of 2, minimum 2.
- CNT_W, 16, width of the drop and error counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- bus_vld  in  1  fetch word accepted by core this cycle.
- bus_adr  in  PAW  word address of fetched word.
- bus_dat  in  16  fetched word.
- bus_flush  in  1  core discarded in-flight fetch (branch, skip, interrupt).
- trc_vld  out  1  record available.
- trc_rdy  in  1  consumer accepts record.
- trc_pc  out  PAW  address of the instruction's first word.
- trc_op  out  32  {second word, first word}; upper half is 0 for 1-word instructions.
- trc_len  out  1  0 = 1-word instruction, 1 = 2-word instruction.
- ovf_cnt  out  CNT_W  records dropped because the FIFO was full; saturating.
- seq_err  out  CNT_W  2-word instructions abandoned on a non-sequential address; saturating.

Behaviour:
- Reset (rst=1 at a clk edge): state=FIRST, FIFO empty, trc_vld=0, trc_pc=0, trc_op=0, trc_len=0, ovf_cnt=0, seq_err=0. A held first word is discarded.
- 2-word detect on the first word:
  - lds/sts: 16'b1001_00??_????_0000.
  - jmp/call: 16'b1001_010?_????_11??.
  - Every other word is a 1-word instruction.
- State FIRST:
  - bus_vld=1 with a 1-word opcode: push {16'h0, dat}, pc=adr, len=0. Stay in FIRST.
  - bus_vld=1 with a 2-word opcode: latch hold_pc=adr and hold_op=dat, go to SECOND. Nothing is pushed.
- State SECOND:
  - bus_vld=1 and adr==hold_pc+1 (modulo 2^PAW): push {dat, hold_op}, pc=hold_pc, len=1, go to FIRST.
  - bus_vld=1 and any other adr: seq_err+1, discard the held word. The new word is processed exactly as in FIRST; it may re-enter SECOND.
  - bus_flush=1: discard the held word and go to FIRST. seq_err is unchanged.
- Flush and word in the same cycle:
  - The flush is applied first.
  - The word is then treated as a first word.
  - bus_flush in FIRST has no effect.
- FIFO:
  - Push at clk edge N makes the record visible at trc_* after edge N. Latency from the completing fetch cycle to trc_vld is 1 cycle when the FIFO is empty.
  - Pop occurs when trc_vld & trc_rdy.
  - trc_* show the head entry and hold stable while trc_vld=1 and trc_rdy=0.
  - trc_vld=0 when empty; trc_pc, trc_op and trc_len then hold their last values.
  - Full with push and no pop: the record is dropped, ovf_cnt+1.
  - Full with push and pop in the same cycle: both occur, no drop.
  - Empty with push and pop in the same cycle: the pop is ignored because trc_vld=0.
  - Records leave in fetch order.
- Counters saturate at 2^CNT_W-1 and clear only on rst.
- No combinational path from bus_* to trc_*. trc_vld does not depend on trc_rdy.

Test Plan:
1. After reset, bus_vld with adr=0x010, dat=0x0C01 (add r0,r1) -> next cycle trc_vld=1, trc_pc=0x010, trc_op=0x00000C01, trc_len=0. With trc_rdy=1, trc_vld=0 one cycle later.
2. adr=0x020 dat=0x9100, then adr=0x021 dat=0x0100 (lds r16,0x0100) -> no record after the first word. After the second word, exactly one record: pc=0x020, op=0x01009100, len=1.
3. adr=0x030 dat=0x940C (jmp), next cycle bus_flush=1 with bus_vld=1, adr=0x040, dat=0x0000 -> one record: pc=0x040, op=0x00000000, len=0. seq_err=0.
4. adr=0x050 dat=0x940E (call), then adr=0x060 dat=0x2700 -> seq_err=1, one record: pc=0x060, op=0x00002700, len=0.
5. trc_rdy=0, FIFO_DEPTH=4, six 1-word fetches at 0x100..0x105 -> trc_vld stays 1 with pc=0x100, ovf_cnt=2. Then trc_rdy=1 -> four records pc=0x100..0x103 in order, then trc_vld=0.
6. FIFO full, trc_rdy=1 and a new fetch in the same cycle -> no drop, ovf_cnt unchanged. Separately, rst=1 while in SECOND (after 0x9200 at 0x070), then adr=0x071 dat=0x0000 -> one record: pc=0x071, len=0. Counters are 0.
